// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD conversion arbiter.
// FSM encodings, digit count, blank code and requester IDs.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int          DIGITS = 3;
  localparam logic [3:0]  BLANK  = 4'hF;
  localparam logic        ID_A   = 1'b0;
  localparam logic        ID_B   = 1'b1;

endpackage

// File: rtl/bcd_conv_arbiter_if.sv
// Request/response bundle between requesters, consumer and arbiter.
// master = requester/consumer side, slave = conversion arbiter.
interface bcd_conv_arbiter_if #(
  parameter int DATA_W = 8
);

  logic              req_a_valid;
  logic [DATA_W-1:0] req_a_data;
  logic              req_a_ready;
  logic              req_b_valid;
  logic [DATA_W-1:0] req_b_data;
  logic              req_b_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [3:0]        rsp_unos;
  logic [3:0]        rsp_dieces;
  logic [3:0]        rsp_cientos;
  logic              busy;

  modport master (
    output req_a_valid, req_a_data,
    output req_b_valid, req_b_data,
    output rsp_ready,
    input  req_a_ready, req_b_ready,
    input  rsp_valid, rsp_id,
    input  rsp_unos, rsp_dieces, rsp_cientos,
    input  busy
  );

  modport slave (
    input  req_a_valid, req_a_data,
    input  req_b_valid, req_b_data,
    input  rsp_ready,
    output req_a_ready, req_b_ready,
    output rsp_valid, rsp_id,
    output rsp_unos, rsp_dieces, rsp_cientos,
    output busy
  );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble cell: a BCD digit >= 5 gets +3 before the shift.
// Purely combinational.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // correct the digit so the following shift carries into the next one
  always_comb begin
    dout = din;
    if (din >= 4'd5) dout = din + 4'd3;
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one shift-and-add-3 BCD converter.
// Optional macro BCD_ZERO_BLANK_EN blanks leading zero digits.
module bcd_conv_arbiter
  import bcd_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  bcd_conv_arbiter_if.slave bus
);

  localparam int DIG_W = DIGITS * 4;
  localparam int SR_W  = DIG_W + DATA_W;
  localparam int CNT_W = 4;

  state_t            state, next_state;
  logic [SR_W-1:0]   sr, sr_adj, sr_next;
  logic [CNT_W-1:0]  cnt;
  logic              last_grant;
  logic              grant_a, grant_b, grant_id;
  logic              accept, last_iter;
  logic [DATA_W-1:0] grant_data;
  logic [3:0]        u_adj, d_adj, c_adj;
  logic [3:0]        u_raw, d_raw, c_raw;
  logic [3:0]        u_out, d_out, c_out;
  logic              rsp_valid_q, rsp_id_q;
  logic [3:0]        unos_q, dieces_q, cientos_q;

  bcd_add3 u_add3_u (.din(sr[DATA_W +: 4]),     .dout(u_adj));
  bcd_add3 u_add3_d (.din(sr[DATA_W+4 +: 4]),   .dout(d_adj));
  bcd_add3 u_add3_c (.din(sr[DATA_W+8 +: 4]),   .dout(c_adj));

  // one double-dabble iteration: correct digits, then shift left
  always_comb begin
    sr_adj  = {c_adj, d_adj, u_adj, sr[DATA_W-1:0]};
    sr_next = {sr_adj[SR_W-2:0], 1'b0};
    u_raw   = sr_next[DATA_W +: 4];
    d_raw   = sr_next[DATA_W+4 +: 4];
    c_raw   = sr_next[DATA_W+8 +: 4];
  end

  // leading-zero blanking applied only at the result latch
  always_comb begin
    u_out = u_raw;
    d_out = d_raw;
    c_out = c_raw;
`ifdef BCD_ZERO_BLANK_EN
    if (c_raw == 4'd0) begin
      c_out = BLANK;
      if (d_raw == 4'd0) d_out = BLANK;
    end
`endif
  end

  // round-robin grant; readies are held low while in reset
  always_comb begin
    grant_b    = bus.req_b_valid &&
                 (!bus.req_a_valid || last_grant == ID_A);
    grant_a    = bus.req_a_valid && !grant_b;
    grant_id   = grant_b ? ID_B : ID_A;
    grant_data = grant_b ? bus.req_b_data : bus.req_a_data;
    accept     = (state == IDLE) && (grant_a || grant_b);
    last_iter  = (cnt == CNT_W'(1));
    bus.req_a_ready = rst_n && (state == IDLE) && grant_a;
    bus.req_b_ready = rst_n && (state == IDLE) && grant_b;
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept)        next_state = SHIFT;
      SHIFT:   if (last_iter)     next_state = DONE;
      DONE:    if (bus.rsp_ready) next_state = IDLE;
      default:                    next_state = IDLE;
    endcase
  end

  // datapath: load, iterate, latch result, release on handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr          <= '0;
      cnt         <= '0;
      last_grant  <= ID_B;
      rsp_id_q    <= ID_A;
      rsp_valid_q <= 1'b0;
      unos_q      <= '0;
      dieces_q    <= '0;
      cientos_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            sr         <= {{DIG_W{1'b0}}, grant_data};
            rsp_id_q   <= grant_id;
            last_grant <= grant_id;
            cnt        <= CNT_W'(DATA_W);
          end
        end
        SHIFT: begin
          sr  <= sr_next;
          cnt <= cnt - CNT_W'(1);
          if (last_iter) begin
            unos_q      <= u_out;
            dieces_q    <= d_out;
            cientos_q   <= c_out;
            rsp_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.rsp_ready) rsp_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // response outputs
  always_comb begin
    bus.rsp_valid   = rsp_valid_q;
    bus.rsp_id      = rsp_id_q;
    bus.rsp_unos    = unos_q;
    bus.rsp_dieces  = dieces_q;
    bus.rsp_cientos = cientos_q;
    bus.busy        = (state != IDLE);
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter: vector table, corner
// sequences and a 0..255 sweep against a divide/modulo model.
module tb_bcd_conv_arbiter;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  bcd_conv_arbiter_if #(.DATA_W(DW)) bus ();

  bcd_conv_arbiter #(.DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit   side;
    int   data;
    int   c;
    int   d;
    int   u;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic void blank(inout int c, inout int d);
`ifdef BCD_ZERO_BLANK_EN
    if (c == 0) begin
      c = 15;
      if (d == 0) d = 15;
    end
`endif
  endfunction

  // wait for rsp_valid at a negedge, bounded
  task automatic wait_rsp(input string tag, output int lat);
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (bus.rsp_valid !== 1'b1) chk({tag, "_timeout"}, 0, 1);
  endtask

  // single request with rsp_ready=1; checks latency, id, digits
  task automatic one_req(input string tag, input bit side,
                         input int data, input int ec,
                         input int ed, input int eu);
    int n;
    int lat;
    int c;
    int d;
    c = ec;
    d = ed;
    blank(c, d);
    @(negedge clk);
    if (side) begin
      bus.req_b_valid = 1'b1;
      bus.req_b_data  = DW'(data);
    end else begin
      bus.req_a_valid = 1'b1;
      bus.req_a_data  = DW'(data);
    end
    n = 0;
    while (((side ? bus.req_b_ready : bus.req_a_ready) !== 1'b1)
           && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"},
        int'(side ? bus.req_b_ready : bus.req_a_ready), 1);
    @(posedge clk);
    @(negedge clk);
    bus.req_a_valid = 1'b0;
    bus.req_b_valid = 1'b0;
    wait_rsp(tag, lat);
    chk({tag, "_latency"}, lat, 8);
    chk({tag, "_id"}, int'(bus.rsp_id), int'(side));
    chk({tag, "_cientos"}, int'(bus.rsp_cientos), c);
    chk({tag, "_dieces"}, int'(bus.rsp_dieces), d);
    chk({tag, "_unos"}, int'(bus.rsp_unos), eu);
    @(negedge clk);
    chk({tag, "_busy_fall"}, int'(bus.busy), 0);
    chk({tag, "_valid_fall"}, int'(bus.rsp_valid), 0);
    chk({tag, "_unos_hold"}, int'(bus.rsp_unos), eu);
  endtask

  initial begin
    int lat;
    int c;
    int d;
    int n;

    vecs[0] = '{side: 1'b0, data: 255, c: 2, d: 5, u: 5};
    vecs[1] = '{side: 1'b1, data: 0,   c: 0, d: 0, u: 0};
    vecs[2] = '{side: 1'b0, data: 9,   c: 0, d: 0, u: 9};
    vecs[3] = '{side: 1'b1, data: 100, c: 1, d: 0, u: 0};
    vecs[4] = '{side: 1'b0, data: 123, c: 1, d: 2, u: 3};
    vecs[5] = '{side: 1'b1, data: 45,  c: 0, d: 4, u: 5};
    vecs[6] = '{side: 1'b0, data: 10,  c: 0, d: 1, u: 0};
    vecs[7] = '{side: 1'b1, data: 209, c: 2, d: 0, u: 9};

    rst_n = 1'b0;
    bus.req_a_valid = 1'b1;
    bus.req_b_valid = 1'b1;
    bus.req_a_data  = DW'(123);
    bus.req_b_data  = DW'(45);
    bus.rsp_ready   = 1'b1;

    // reset with both requesters valid
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      chk("rst_valid", int'(bus.rsp_valid), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_ready_a", int'(bus.req_a_ready), 0);
      chk("rst_ready_b", int'(bus.req_b_ready), 0);
    end
    rst_n = 1'b1;
    #1;
    chk("first_ready_a", int'(bus.req_a_ready), 1);
    chk("first_ready_b", int'(bus.req_b_ready), 0);

    // contention: strict alternation A,B,A,B with held valids
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      wait_rsp("cont", lat);
      chk("cont_id", int'(bus.rsp_id), k % 2);
      c = (k % 2) ? 0 : 1;
      d = (k % 2) ? 4 : 2;
      blank(c, d);
      chk("cont_cientos", int'(bus.rsp_cientos), c);
      chk("cont_dieces", int'(bus.rsp_dieces), d);
      chk("cont_unos", int'(bus.rsp_unos), (k % 2) ? 5 : 3);
      if (k == 3) begin
        bus.req_a_valid = 1'b0;
        bus.req_b_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("cont_idle", int'(bus.busy), 0);

    // table-driven single requests
    for (int i = 0; i < 8; i++)
      one_req($sformatf("vec%0d", i), vecs[i].side, vecs[i].data,
              vecs[i].c, vecs[i].d, vecs[i].u);

    // backpressure: A=77 stalled 5 clocks, B waiting
    bus.rsp_ready = 1'b0;
    one_req_bp: begin
      @(negedge clk);
      bus.req_a_valid = 1'b1;
      bus.req_a_data  = DW'(77);
      @(posedge clk);
      @(negedge clk);
      bus.req_a_valid = 1'b0;
      bus.req_b_valid = 1'b1;
      bus.req_b_data  = DW'(33);
      wait_rsp("bp", lat);
      chk("bp_latency", lat, 8);
      c = 0;
      d = 7;
      blank(c, d);
      repeat (5) begin
        @(negedge clk);
        chk("bp_valid", int'(bus.rsp_valid), 1);
        chk("bp_id", int'(bus.rsp_id), 0);
        chk("bp_cientos", int'(bus.rsp_cientos), c);
        chk("bp_dieces", int'(bus.rsp_dieces), d);
        chk("bp_unos", int'(bus.rsp_unos), 7);
        chk("bp_ready_a", int'(bus.req_a_ready), 0);
        chk("bp_ready_b", int'(bus.req_b_ready), 0);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", int'(bus.rsp_valid), 0);
      chk("bp_release_busy", int'(bus.busy), 0);
      chk("bp_release_ready_b", int'(bus.req_b_ready), 1);
      @(posedge clk);
      @(negedge clk);
      bus.req_b_valid = 1'b0;
      wait_rsp("bp_b", lat);
      chk("bp_b_latency", lat, 8);
      chk("bp_b_id", int'(bus.rsp_id), 1);
      chk("bp_b_unos", int'(bus.rsp_unos), 3);
      @(negedge clk);
    end

    // reset on the 3rd SHIFT clock of B=200
    bus.req_b_valid = 1'b1;
    bus.req_b_data  = DW'(200);
    #1;
    chk("mr_ready_b", int'(bus.req_b_ready), 1);
    @(posedge clk);
    @(negedge clk);
    bus.req_b_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mr_busy", int'(bus.busy), 0);
    n = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) n++;
    end
    chk("mr_no_rsp", n, 0);
    bus.req_a_valid = 1'b1;
    bus.req_b_valid = 1'b1;
    #1;
    chk("mr_regrant_a", int'(bus.req_a_ready), 1);
    chk("mr_regrant_b", int'(bus.req_b_ready), 0);
    bus.req_a_valid = 1'b0;
    bus.req_b_valid = 1'b0;

    // sweep 0..255 alternating A/B
    for (int v = 0; v < 256; v++)
      one_req("sweep", v[0], v, v / 100, (v / 10) % 10, v % 10);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
